// File: rtl/multi_timer.sv
// Multi-channel programmable interval timer: CH independent down-the-line interval
// channels, one-shot or periodic, all paced by one shared clock prescaler.
module multi_timer #(
  parameter int unsigned CH    = 4,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned PRE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PRE_W-1:0]      prescale,
  input  logic [CH-1:0]         start,
  input  logic [CH-1:0]         stop,
  input  logic [CH-1:0]         periodic,
  input  logic [CH*WIDTH-1:0]   setcount,
  output logic [CH-1:0]         timeout,
  output logic [CH-1:0]         busy,
  output logic [CH*WIDTH-1:0]   count
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;

  assign tick = (pre_cnt == prescale);

  // Shared prescaler; parked at 0 whenever every channel is idle so a fresh start is phase-aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt <= '0;
    end else if (!(|busy)) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] period_q;
    logic [WIDTH-1:0] period_d;
    logic             mode_q;
    logic             mode_d;
    logic             to_q;
    logic             to_d;
    logic             term;

    // Terminal tick: the interval's last tick lands this cycle.
    assign term = tick && (cnt_q == period_q);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= IDLE;
      end else begin
        state_q <= state_d;
      end
    end

    // Next state; stop beats start beats tick.
    always_comb begin
      state_d = state_q;
      case (state_q)
        IDLE: begin
          if (!stop[g] && start[g]) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (stop[g]) begin
            state_d = IDLE;
          end else if (start[g]) begin
            state_d = RUN;
          end else if (term && !mode_q) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Count, latched configuration and timeout pulse.
    always_comb begin
      cnt_d    = cnt_q;
      period_d = period_q;
      mode_d   = mode_q;
      to_d     = 1'b0;
      case (state_q)
        IDLE: begin
          if (!stop[g] && start[g]) begin
            period_d = setcount[g*WIDTH +: WIDTH];
            mode_d   = periodic[g];
            cnt_d    = '0;
          end
        end
        RUN: begin
          if (stop[g]) begin
            cnt_d = '0;
          end else if (start[g]) begin
            period_d = setcount[g*WIDTH +: WIDTH];
            mode_d   = periodic[g];
            cnt_d    = '0;
          end else if (term) begin
            to_d  = 1'b1;
            cnt_d = '0;
          end else if (tick) begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end
        default: begin
          cnt_d = '0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q    <= '0;
        period_q <= '0;
        mode_q   <= 1'b0;
        to_q     <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        period_q <= period_d;
        mode_q   <= mode_d;
        to_q     <= to_d;
      end
    end

    assign busy[g]                  = (state_q == RUN);
    assign timeout[g]               = to_q;
    assign count[g*WIDTH +: WIDTH]  = cnt_q;
  end

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: tick-counting reference model plus directed scenarios.
module tb_multi_timer;
  localparam int CH = 4;
  localparam int W  = 16;
  localparam int PW = 8;

  logic            clk;
  logic            rst;
  logic [PW-1:0]   prescale;
  logic [CH-1:0]   start;
  logic [CH-1:0]   stop;
  logic [CH-1:0]   periodic;
  logic [CH*W-1:0] setcount;
  logic [CH-1:0]   timeout;
  logic [CH-1:0]   busy;
  logic [CH*W-1:0] count;

  multi_timer #(.CH(CH), .WIDTH(W), .PRE_W(PW)) dut (
    .clk(clk), .rst(rst), .prescale(prescale), .start(start), .stop(stop),
    .periodic(periodic), .setcount(setcount), .timeout(timeout), .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: ticks elapsed in the current interval, prescaler as cycles-since-activity.
  int m_busy[CH];
  int m_ticks[CH];
  int m_len[CH];
  int m_mode[CH];
  int m_to[CH];
  int m_run;
  int m_any;
  int m_tk;

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_busy[i] = 0; m_ticks[i] = 0; m_len[i] = 1; m_mode[i] = 0; m_to[i] = 0;
    end
    m_run = 0;
  endtask

  task automatic model_step();
    m_any = 0;
    for (int i = 0; i < CH; i++) if (m_busy[i] != 0) m_any = 1;
    m_tk  = (m_any != 0) && ((m_run % (int'(prescale) + 1)) == int'(prescale));
    m_run = (m_any != 0) ? m_run + 1 : 0;
    for (int i = 0; i < CH; i++) begin
      m_to[i] = 0;
      if (stop[i]) begin
        m_busy[i] = 0; m_ticks[i] = 0;
      end else if (start[i]) begin
        m_busy[i] = 1; m_ticks[i] = 0;
        m_len[i]  = int'(setcount[i*W +: W]) + 1;
        m_mode[i] = int'(periodic[i]);
      end else if (m_busy[i] != 0 && m_tk != 0) begin
        m_ticks[i]++;
        if (m_ticks[i] == m_len[i]) begin
          m_to[i] = 1; m_ticks[i] = 0;
          if (m_mode[i] == 0) m_busy[i] = 0;
        end
      end
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else      model_step();
  end

  // Every-cycle comparison of the full output vectors against the model.
  logic [CH-1:0]   e_to;
  logic [CH-1:0]   e_busy;
  logic [CH*W-1:0] e_cnt;
  always @(negedge clk) begin
    for (int i = 0; i < CH; i++) begin
      e_to[i]          = (m_to[i] != 0);
      e_busy[i]        = (m_busy[i] != 0);
      e_cnt[i*W +: W]  = W'(m_ticks[i]);
    end
    chk("model_timeout", 64'(timeout), 64'(e_to));
    chk("model_busy", 64'(busy), 64'(e_busy));
    chk("model_count", 64'(count), 64'(e_cnt));
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  int q0[$];
  int q1[$];
  int q3[$];
  int first;
  int hits;
  int exp_cnt[5]  = '{0, 1, 2, 3, 0};
  int exp_to[5]   = '{0, 0, 0, 0, 1};
  int exp_busy[5] = '{1, 1, 1, 1, 0};
  int exp_p[4]    = '{6, 12, 18, 24};
  int exp_i0[3]   = '{3, 6, 9};
  int exp_i3[5]   = '{6, 11, 16, 21, 26};

  initial begin
    clk = 1'b0; rst = 1'b0; prescale = '0; start = '0; stop = '0;
    periodic = '0; setcount = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_timeout", 64'(timeout), 64'd0);
    chk("reset_count", 64'(count), 64'd0);
    rst = 1'b1;
    cyc();

    // Basic one-shot, prescale 0, CH0 period 3.
    setcount[0*W +: W] = 16'd3; periodic[0] = 1'b0; start[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      start[0] = 1'b0;
      chk("oneshot_count", 64'(count[0 +: W]), 64'(exp_cnt[k]));
      chk("oneshot_timeout", 64'(timeout[0]), 64'(exp_to[k]));
      chk("oneshot_busy", 64'(busy[0]), 64'(exp_busy[k]));
    end
    cyc();
    chk("oneshot_pulse_width", 64'(timeout[0]), 64'd0);

    // Prescaled periodic, prescale 2, CH1 period 1.
    prescale = 8'd2;
    setcount[1*W +: W] = 16'd1; periodic[1] = 1'b1; start[1] = 1'b1;
    cyc();
    start[1] = 1'b0;
    q1.delete();
    for (int k = 1; k <= 25; k++) begin
      cyc();
      if (timeout[1]) q1.push_back(k);
    end
    chk("presc_pulses", 64'(q1.size()), 64'd4);
    for (int i = 0; i < 4 && i < q1.size(); i++) chk("presc_pulse_at", 64'(q1[i]), 64'(exp_p[i]));
    chk("presc_busy", 64'(busy[1]), 64'd1);
    stop[1] = 1'b1;
    cyc();
    stop[1] = 1'b0;
    chk("presc_stop_busy", 64'(busy[1]), 64'd0);
    prescale = 8'd0;

    // Stop on the terminal tick: CH2 period 5.
    setcount[2*W +: W] = 16'd5; periodic[2] = 1'b0; start[2] = 1'b1;
    cyc();
    start[2] = 1'b0;
    repeat (5) cyc();
    chk("stopcol_count5", 64'(count[2*W +: W]), 64'd5);
    stop[2] = 1'b1;
    cyc();
    stop[2] = 1'b0;
    chk("stopcol_timeout", 64'(timeout[2]), 64'd0);
    chk("stopcol_busy", 64'(busy[2]), 64'd0);
    cyc();
    chk("stopcol_timeout_late", 64'(timeout[2]), 64'd0);

    // Restart on the terminal tick, then a fresh 6-tick interval.
    start[2] = 1'b1;
    cyc();
    start[2] = 1'b0;
    repeat (5) cyc();
    start[2] = 1'b1;
    cyc();
    start[2] = 1'b0;
    chk("restart_timeout", 64'(timeout[2]), 64'd0);
    chk("restart_count", 64'(count[2*W +: W]), 64'd0);
    chk("restart_busy", 64'(busy[2]), 64'd1);
    first = -1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (timeout[2] && first < 0) first = k;
    end
    chk("restart_len", 64'(first), 64'd6);

    // Period 0 periodic: timeout every cycle; stop suppresses the coinciding pulse.
    setcount[0*W +: W] = 16'd0; periodic[0] = 1'b1; start[0] = 1'b1;
    cyc();
    start[0] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      chk("zero_period_timeout", 64'(timeout[0]), 64'd1);
    end
    stop[0] = 1'b1;
    cyc();
    stop[0] = 1'b0;
    chk("zero_period_stop", 64'(timeout[0]), 64'd0);

    // Full-range one-shot on CH3: 65536 ticks.
    setcount[3*W +: W] = 16'hFFFF; periodic[3] = 1'b0; start[3] = 1'b1;
    cyc();
    start[3] = 1'b0;
    first = -1;
    for (int k = 1; k <= 65540; k++) begin
      cyc();
      if (timeout[3] && first < 0) first = k;
    end
    chk("max_period_len", 64'(first), 64'd65536);
    chk("max_period_busy", 64'(busy[3]), 64'd0);

    // Independence: CH0 period 2 and CH3 period 4, started one cycle apart; CH0 stopped at E10.
    setcount[0*W +: W] = 16'd2; periodic[0] = 1'b1;
    setcount[3*W +: W] = 16'd4; periodic[3] = 1'b1;
    start[0] = 1'b1;
    cyc();
    start[0] = 1'b0; start[3] = 1'b1;
    q0.delete(); q3.delete();
    for (int k = 1; k <= 30; k++) begin
      if (k == 10) stop[0] = 1'b1;
      cyc();
      start[3] = 1'b0; stop[0] = 1'b0;
      if (timeout[0]) q0.push_back(k);
      if (timeout[3]) q3.push_back(k);
    end
    chk("ind_ch0_pulses", 64'(q0.size()), 64'd3);
    for (int i = 0; i < 3 && i < q0.size(); i++) chk("ind_ch0_at", 64'(q0[i]), 64'(exp_i0[i]));
    chk("ind_ch3_pulses", 64'(q3.size()), 64'd5);
    for (int i = 0; i < 5 && i < q3.size(); i++) chk("ind_ch3_at", 64'(q3[i]), 64'(exp_i3[i]));
    stop[3] = 1'b1;
    cyc();
    stop[3] = 1'b0;

    // Async reset mid-run with two channels active.
    prescale = 8'd1;
    setcount[1*W +: W] = 16'd10; periodic[1] = 1'b1;
    setcount[2*W +: W] = 16'd7;  periodic[2] = 1'b0;
    start[1] = 1'b1; start[2] = 1'b1;
    cyc();
    start = '0;
    repeat (5) cyc();
    chk("arst_pre_busy", 64'(busy), 64'h6);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_timeout", 64'(timeout), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    @(negedge clk);
    #1 rst = 1'b1;
    hits = 0;
    for (int k = 0; k < 12; k++) begin
      cyc();
      if (timeout != '0) hits++;
    end
    chk("arst_no_pulse", 64'(hits), 64'd0);

    // Fresh start after reset: CH0 period 1, prescale 0 -> pulse after E2.
    prescale = 8'd0;
    setcount[0*W +: W] = 16'd1; periodic[0] = 1'b0; start[0] = 1'b1;
    cyc();
    start[0] = 1'b0;
    first = -1;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      if (timeout[0] && first < 0) first = k;
    end
    chk("post_reset_len", 64'(first), 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_timer.md
# multi_timer

Multi-channel programmable interval timer for sequencing illumination phases, e.g. polarization-state dwell times and LED settle windows. It provides CH independent WIDTH-bit down-the-line interval channels driven by one shared clock prescaler. Each channel runs one-shot or periodic and emits a single-cycle timeout pulse. The block sits between the sequencer FSM, which supplies start, stop and setcount per channel, and the LED/shutter drive logic, which consumes timeout.

## Interface

- CH, 4: number of independent timer channels
- WIDTH, 16: channel counter and setcount width
- PRE_W, 8: prescaler width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- prescale  in  PRE_W  tick divider; one tick every prescale+1 clk cycles
- start  in  CH  per-channel start/restart strobe, sampled each clk
- stop  in  CH  per-channel abort strobe
- periodic  in  CH  mode, latched at start: 1 = auto-reload, 0 = one-shot
- setcount  in  CH*WIDTH  terminal count per channel; channel i uses bits [i*WIDTH +: WIDTH], latched at start
- timeout  out  CH  registered one-cycle pulse at interval end
- busy  out  CH  registered; channel in RUN
- count  out  CH*WIDTH  registered current count per channel

## Operation

- Shared prescaler pre_cnt (PRE_W bits):
  - Held at 0 while no channel is busy.
  - Otherwise counts 0..prescale and wraps to 0.
  - tick = (pre_cnt == prescale).
  - prescale = 0 gives tick every cycle.
  - A prescale change mid-run takes effect on the next compare. If pre_cnt > prescale, pre_cnt wraps naturally through its maximum value; no special handling.
- Per-channel FSM with states IDLE and RUN. Priority per cycle: stop > start > tick.
  - IDLE + start: latch setcount into period[i] and periodic into mode[i]; count <= 0, busy <= 1, enter RUN.
  - RUN + stop: count <= 0, busy <= 0, go to IDLE. No timeout, even if a terminal tick coincides.
  - RUN + start (no stop): restart. Reload period and mode, count <= 0. No timeout, even if a terminal tick coincides.
  - RUN + tick, count != period: count <= count + 1.
  - RUN + tick, count == period:
    - timeout[i] <= 1 for one cycle.
    - Periodic: count <= 0, stay in RUN.
    - One-shot: count <= 0, busy <= 0, go to IDLE.
  - IDLE + stop: no effect.
- timeout is 0 in every cycle not described above.
- Interval length is (period+1) ticks. period = 0 gives a timeout on the first tick.
- period = 2^WIDTH-1 is legal. count never exceeds period, so no counter overflow occurs.
- Channels are fully independent except for the shared prescaler phase.
- Reset (asynchronous, any time, including mid-run): all channels go to IDLE; count, busy, timeout and pre_cnt are all 0. No pulse is generated on reset release.

## Timing

- Start sampled at edge E0 with all channels idle: the first tick occurs at E(prescale+1), and timeout is high for the cycle following E((period+1)*(prescale+1)).
- Start while another channel is already busy: the prescaler phase is arbitrary. The first tick falls between 1 and prescale+1 cycles after E0. Total latency is (period)*(prescale+1)+1 to (period+1)*(prescale+1) cycles.
- Periodic mode: timeout pulses are spaced exactly (period+1)*(prescale+1) cycles apart.
- busy rises the cycle after start. One-shot busy falls in the same cycle timeout rises.
- stop: busy falls the cycle after stop.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan

- Basic one-shot, prescale=0: CH0 setcount=3, periodic=0, start pulse at E0 -> timeout[0] high only in the cycle after E4. busy[0] high from E0 through E4. count[0] shows 0,1,2,3,0.
- Prescaled periodic: prescale=2, CH1 setcount=1, periodic=1 -> first timeout[1] after E6, then every 6 cycles for at least 4 pulses. busy[1] stays 1.
- Stop/restart collision:
  - CH2 setcount=5 with stop asserted on the terminal-tick cycle -> no timeout, busy[2]=0 next cycle.
  - Repeat with start instead -> no timeout, count[2]=0, and a new interval of 6 ticks.
- Edge values: setcount=0 with prescale=0 -> timeout every cycle in periodic mode. setcount=16'hFFFF one-shot -> timeout after exactly 65536 cycles, with no wrap glitch.
- Independence: CH0=2 and CH3=4, both periodic, started 1 cycle apart -> correct spacing on each channel. Stopping CH0 does not disturb CH3's cadence.
- Async reset mid-run: assert rst low between edges while 2 channels are running -> busy, timeout and count go to 0 immediately. After release, no timeout until a new start.
